// File: rtl/mcd_snd_mix.sv
// mcd_snd_mix: Mega-CD audio output stage.
// CD-DA pairs are buffered in a small FIFO and popped once per I2S frame.
// The popped pair is scaled by the fader, mixed with PCM (saturating), and
// shifted out MSB-first to an external I2S DAC.
// Build option: define MCD_SND_PCM_EN to mix the PCM inputs. Without it the
// PCM inputs are ignored and the output equals the faded CD-DA, still
// passed through the same saturation stage.
`timescale 1ns/1ps
module mcd_snd_mix #(
    parameter int BCK_HALF   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          map_rst_n,
    input  logic                          mcd_on,
    input  logic [15:0]                   cdda_l,
    input  logic [15:0]                   cdda_r,
    input  logic                          cdda_we,
    input  logic [9:0]                    cdda_vol,
    input  logic [15:0]                   pcm_l,
    input  logic [15:0]                   pcm_r,
    output logic                          dac_bck,
    output logic                          dac_lrck,
    output logic                          dac_dat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
    output logic                          fifo_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(BCK_HALF);

    logic [DW-1:0] r_div;
    logic          r_bck, r_lrck, r_dat;
    logic [5:0]    r_cnt;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [LW-1:0] r_lvl;
    logic          r_ovf;
    logic [31:0]   r_hold;
    logic [1:0]    r_vld_pipe;
    logic [15:0]   r_cd_l, r_cd_r;
    logic [31:0]   r_sh;

    // Bit clock edges and frame timing
    logic       w_wrap, w_fall, w_fstart, w_data_slot;
    logic [5:0] w_slot;
    assign w_wrap      = (r_div == DW'(BCK_HALF - 1));
    assign w_fall      = w_wrap & r_bck;
    assign w_fstart    = w_fall & (r_cnt == 6'd63);
    assign w_slot      = r_cnt + 6'd1;
    assign w_data_slot = ((w_slot >= 6'd1)  && (w_slot <= 6'd16)) ||
                         ((w_slot >= 6'd33) && (w_slot <= 6'd48));

    // FIFO handshakes; a full FIFO still accepts a push when a pop frees a slot
    logic w_pop, w_push, w_drop;
    assign w_pop  = mcd_on & w_fstart & (r_lvl != '0);
    assign w_push = mcd_on & cdda_we & ((r_lvl != LW'(FIFO_DEPTH)) | w_pop);
    assign w_drop = mcd_on & cdda_we & ~w_push;

    // Fader: signed sample times unsigned 10-bit gain, then divide by 1024
    logic signed [25:0] w_prod_l, w_prod_r;
    assign w_prod_l = $signed({{10{r_hold[31]}}, r_hold[31:16]}) * $signed({16'd0, cdda_vol});
    assign w_prod_r = $signed({{10{r_hold[15]}}, r_hold[15:0]})  * $signed({16'd0, cdda_vol});

    // Mix at 17 bits so the saturation stage can see the overflow
    logic [16:0] w_sum_l, w_sum_r;
`ifdef MCD_SND_PCM_EN
    logic [15:0] r_pcm_l, r_pcm_r;
    assign w_sum_l = {r_cd_l[15], r_cd_l} + {r_pcm_l[15], r_pcm_l};
    assign w_sum_r = {r_cd_r[15], r_cd_r} + {r_pcm_r[15], r_pcm_r};
`else
    logic w_unused_pcm;
    assign w_unused_pcm = ^{pcm_l, pcm_r};
    assign w_sum_l = {r_cd_l[15], r_cd_l};
    assign w_sum_r = {r_cd_r[15], r_cd_r};
`endif

    function automatic logic [15:0] sat16(input logic [16:0] s);
        case (s[16:15])
            2'b01:   return 16'h7FFF;
            2'b10:   return 16'h8000;
            default: return s[15:0];
        endcase
    endfunction

    // BCK divider, bit counter and word select; all data moves on BCK falls
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            r_div  <= '0;
            r_bck  <= 1'b0;
            r_cnt  <= 6'd63;
            r_lrck <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_div <= '0;
                r_bck <= ~r_bck;
            end else begin
                r_div <= r_div + DW'(1);
            end
            if (w_fall) begin
                r_cnt  <= w_slot;
                r_lrck <= w_slot[5];
            end
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {cdda_l, cdda_r};
    end

    // FIFO pointers, level, sticky overflow, and the held (last popped) pair
    always_ff @(posedge clk) begin
        if (!map_rst_n || !mcd_on) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_lvl  <= '0;
            r_ovf  <= 1'b0;
            r_hold <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) begin
                r_rp   <= r_rp + AW'(1);
                r_hold <= r_mem[r_rp];
            end
            if (w_push && !w_pop)      r_lvl <= r_lvl + LW'(1);
            else if (!w_push && w_pop) r_lvl <= r_lvl - LW'(1);
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Two-stage mix pipeline launched at each frame start
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            r_vld_pipe <= '0;
            r_cd_l     <= '0;
            r_cd_r     <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_fstart};
            if (r_vld_pipe[0]) begin
                r_cd_l <= 16'(w_prod_l >>> 10);
                r_cd_r <= 16'(w_prod_r >>> 10);
            end
        end
    end

`ifdef MCD_SND_PCM_EN
    // PCM is level-held upstream; capture it alongside the FIFO pop
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            r_pcm_l <= '0;
            r_pcm_r <= '0;
        end else if (w_fstart) begin
            r_pcm_l <= pcm_l;
            r_pcm_r <= pcm_r;
        end
    end
`endif

    // Output shifter: load the mixed pair, shift one bit per data slot
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            r_sh  <= '0;
            r_dat <= 1'b0;
        end else begin
            if (!mcd_on)
                r_sh <= '0;
            else if (r_vld_pipe[1])
                r_sh <= {sat16(w_sum_l), sat16(w_sum_r)};
            else if (w_fall && w_data_slot)
                r_sh <= {r_sh[30:0], 1'b0};
            if (!mcd_on)
                r_dat <= 1'b0;
            else if (w_fall)
                r_dat <= w_data_slot ? r_sh[31] : 1'b0;
        end
    end

    assign dac_bck  = r_bck;
    assign dac_lrck = r_lrck;
    assign dac_dat  = r_dat;
    assign fifo_lvl = r_lvl;
    assign fifo_ovf = r_ovf;
endmodule
